// File: rtl/fib_bcd_converter.sv
// fib_bcd_converter
//
// Sequential binary-to-BCD converter placed downstream of the Fibonacci
// series generator. One IN_W-bit term is accepted per valid/ready handshake
// and converted with the shift-and-add-3 (double-dabble) iteration, one shift
// per cycle. The packed BCD result and a significant-digit count are then
// held for the display/UART stage until it accepts them.
//
// Parameters:
//   IN_W    binary input width; conversion takes IN_W shift cycles
//   DIGITS  BCD digits produced; must be >= ceil(IN_W*log10(2)), and <= 15
//           so the digit count fits out_ndig
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   in_value holds a term to convert
//   in_ready   converter idle and able to accept a term
//   in_value   unsigned binary term
//   out_valid  out_bcd/out_ndig hold a completed result
//   out_ready  downstream accepts the result
//   out_bcd    packed BCD, digit 0 (units) in bits [3:0]
//   out_ndig   significant-digit count, 1..DIGITS
//   busy       conversion in progress
//
// Build option:
//   FIB_BCD_LEADING_ZERO_BLANK_EN  when defined, digits above out_ndig-1 are
//   driven as 4'hF (display blank code); digit 0 is never blanked. When
//   undefined, leading digits read as 4'h0.

module fib_bcd_converter #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [3:0]          out_ndig,
  output logic                busy
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned RegW = BcdW + IN_W;
  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(IN_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  // BCD field in the upper BcdW bits, binary term shifting out of the lower IN_W bits.
  logic [RegW-1:0] shift_q, shift_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic [3:0]      ndig_q, ndig_d;

  logic [RegW-1:0] shift_adj;
  logic [RegW-1:0] shifted;
  logic [3:0]      ndig_new;

  // Add 3 to every BCD nibble >= 5 so that the following shift carries
  // correctly into the next decimal digit. The binary part is untouched.
  always_comb begin
    shift_adj = shift_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (shift_q[IN_W + 4*d +: 4] >= 4'd5) begin
        shift_adj[IN_W + 4*d +: 4] = shift_q[IN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {shift_adj[RegW-2:0], 1'b0};

  // Digit count of the value produced by the current shift; only used on the
  // final shift, when the BCD field is complete.
  always_comb begin
    ndig_new = 4'd1;
    for (int d = 1; d < int'(DIGITS); d++) begin
      if (shifted[IN_W + 4*d +: 4] != 4'd0) begin
        ndig_new = 4'(d + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = {{BcdW{1'b0}}, in_value};
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bcd_d   = shifted[RegW-1:IN_W];
          ndig_d  = ndig_new;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ndig_q  <= 4'd1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StShift);
  assign out_ndig  = ndig_q;

`ifdef FIB_BCD_LEADING_ZERO_BLANK_EN
  // Digit 0 is always shown so that zero still displays as "0".
  always_comb begin
    out_bcd = bcd_q;
    for (int d = 1; d < int'(DIGITS); d++) begin
      if (d >= int'(ndig_q)) begin
        out_bcd[4*d +: 4] = 4'hF;
      end
    end
  end
`else
  assign out_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_fib_bcd_converter.sv
module tb_fib_bcd_converter;

`ifdef FIB_BCD_LEADING_ZERO_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_bcd;
  logic [3:0]  out_ndig;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fib_bcd_converter #(
    .IN_W  (32),
    .DIGITS(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bcd  (out_bcd),
    .out_ndig (out_ndig),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] v;
    logic [39:0] bcd;
    logic [3:0]  ndig;
  } vec_t;

  vec_t vecs [0:6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [39:0] ref_bcd(input logic [31:0] v);
    longint unsigned x = 64'(v);
    logic [39:0] r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_ndig(input logic [31:0] v);
    longint unsigned x = 64'(v);
    int n = 1;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return 4'(n);
  endfunction

  // What the output port shows for a given result in this build.
  function automatic logic [39:0] shown(input logic [39:0] b, input logic [3:0] n);
    logic [39:0] r = b;
    for (int d = 1; d < 10; d++) begin
      if (Blank && d >= int'(n)) r[4*d +: 4] = 4'hF;
    end
    return r;
  endfunction

  // Accept one term, wait for its result, check it, stall, then hand it off.
  // keep_ready: out_ready is already held high (back-to-back operation).
  task automatic run_term(input logic [31:0] v, input logic [39:0] exp_bcd,
                          input logic [3:0] exp_ndig, input int stall,
                          input bit keep_ready, input string tag);
    int lat;
    bit bad_nib;
    bit unstable;
    logic [39:0] exp_out;
    exp_out = shown(exp_bcd, exp_ndig);
    check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk); #1;
    check({tag, "/busy_after_accept"}, 64'({busy, in_ready}), 64'b10);
    lat = 0;
    bad_nib = 1'b0;
    while (!out_valid && lat < 100) begin
      // Upstream noise during the conversion must be ignored.
      in_valid = 1'($urandom);
      in_value = $urandom;
      for (int d = 0; d < 10; d++) begin
        if (dut.shift_q[32 + 4*d +: 4] > 4'd9) bad_nib = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'd32);
    check({tag, "/nibble_le_9"}, 64'(bad_nib), 64'd0);
    check({tag, "/out_bcd"}, 64'(out_bcd), 64'(exp_out));
    check({tag, "/out_ndig"}, 64'(out_ndig), 64'(exp_ndig));
    check({tag, "/done_flags"}, 64'({in_ready, busy}), 64'b00);
    if (!keep_ready) begin
      unstable = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || out_bcd !== exp_out || out_ndig !== exp_ndig)
          unstable = 1'b1;
      end
      if (stall > 0) check({tag, "/stall_stable"}, 64'(unstable), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    if (!keep_ready) out_ready = 1'b0;
    check({tag, "/after_handshake"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/rst_flags"}, 64'({in_ready, out_valid, busy}), 64'b100);
    check({tag, "/rst_bcd"}, 64'(out_bcd), 64'(shown(40'h0, 4'd1)));
    check({tag, "/rst_ndig"}, 64'(out_ndig), 64'd1);
  endtask

  initial begin
    logic [31:0] rv;
    int wait_n;
    bit saw_valid;

    vecs[0] = '{32'd0,          40'h0000000000, 4'd1};
    vecs[1] = '{32'd1,          40'h0000000001, 4'd1};
    vecs[2] = '{32'd2971215073, 40'h2971215073, 4'd10};
    vecs[3] = '{32'hFFFFFFFF,   40'h4294967295, 4'd10};
    vecs[4] = '{32'd144,        40'h0000000144, 4'd3};
    vecs[5] = '{32'd9,          40'h0000000009, 4'd1};
    vecs[6] = '{32'd1000000000, 40'h1000000000, 4'd10};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // First term offered immediately after reset release.
    for (int i = 0; i < 7; i++) begin
      run_term(vecs[i].v, vecs[i].bcd, vecs[i].ndig, 2, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-to-back: DONE lasts exactly one cycle with out_ready held high.
    out_ready = 1'b1;
    run_term(32'd1, 40'h0000000001, 4'd1, 0, 1'b1, "b2b_1");
    run_term(32'd2971215073, 40'h2971215073, 4'd10, 0, 1'b1, "b2b_f47");
    out_ready = 1'b0;

    // Long output stall.
    run_term(32'd832040, 40'h0000832040, 4'd6, 50, 1'b0, "stall_f30");

    // Reset in the middle of SHIFT.
    in_valid = 1'b1;
    in_value = 32'd12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("rst_shift");
    @(posedge clk); #1;
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_shift/no_out_valid", 64'(saw_valid), 64'd0);
    run_term(32'd144, 40'h0000000144, 4'd3, 1, 1'b0, "after_rst_144");

    // Reset while a result is waiting in DONE.
    in_valid = 1'b1;
    in_value = 32'd2971215073;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 100) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("rst_done/reached_done", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("rst_done");
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized terms against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rv = (i % 3 == 0) ? 32'($urandom_range(0, 9999)) : $urandom;
      run_term(rv, ref_bcd(rv), ref_ndig(rv), int'($urandom_range(0, 3)), 1'b0,
               $sformatf("rand%0d_%0d", i, rv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_bcd_converter.md
# fib_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the Fibonacci series generator. It accepts one 32-bit term per valid/ready handshake and converts it with a shift-and-add-3 (double-dabble) iteration. It presents the packed BCD digits and a significant-digit count to the display/UART stage, holding the result until that stage accepts it.

## Interface
- IN_W, 32: binary input width; conversion latency equals IN_W shift cycles.
- DIGITS, 10: BCD digits produced; must satisfy DIGITS >= ceil(IN_W*log10(2)), which gives 10 for 32.
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- in_valid  input  1  in_value holds a term to convert.
- in_ready  output  1  converter idle and able to accept a term.
- in_value  input  IN_W  unsigned binary term (upstream series_value).
- out_valid  output  1  out_bcd/out_ndig hold a completed result.
- out_ready  input  1  downstream accepts the result.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- out_ndig  output  4  significant-digit count, 1..DIGITS.
- busy  output  1  high in SHIFT state.

## Operation
- FSM states IDLE, SHIFT, DONE; reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - load shift register = {4*DIGITS zeros, in_value};
  - clear bit counter;
  - go to SHIFT.
- SHIFT, once per cycle:
  - add 3 to every BCD nibble >= 5;
  - shift the whole register left by 1;
  - increment the counter.
  - After the IN_W-th shift, latch the BCD field into out_bcd, compute out_ndig, go to DONE.
- DONE: out_valid=1, outputs stable. On out_ready, go to IDLE.
- in_value is sampled only at acceptance; later changes to it are ignored.
- out_ndig = index of the highest nonzero digit + 1. A value of 0 gives 1.
- No nibble ever exceeds 9. There is no overflow, given the DIGITS constraint.
- Reset values: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, out_bcd=0, out_ndig=1, counter=0.

## Timing
- Acceptance at edge N. SHIFT spans edges N+1..N+IN_W. out_valid rises after edge N+IN_W, which is 32 cycles for default parameters.
- in_ready is low from edge N+1 until the edge after the out_ready handshake.
- Minimum period between accepted terms is IN_W+2 cycles.
- Back-to-back: out_ready held high gives a DONE state of exactly one cycle.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored. There is no internal queue, so upstream must hold its term.
- Output backpressure: out_bcd/out_ndig stay unchanged for the whole DONE period, for any length of stall.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to IDLE with the reset values above. The partial result is discarded and no out_valid pulse occurs.
- Reset release: the first acceptance is possible at the first rising edge with reset low.

## Configuration
- FIB_BCD_LEADING_ZERO_BLANK_EN defined:
  - every digit above out_ndig-1 is driven as 4'hF (blank code for the display stage);
  - digit 0 is never blanked, so value 0 reads ...FFF0.
- Undefined: leading digits are driven as 4'h0. out_ndig is produced in both builds.

## Test plan
- Reset, then in_value=0 -> after 32 cycles out_bcd=40'h0000000000, out_ndig=1 (blank build: 40'hFFFFFFFFF0).
- in_value=1 then 2971215073 (F47), out_ready=1 -> out_bcd=40'h0000000001 with ndig 1, then 40'h2971215073 with ndig 10; each result exactly 32 cycles after acceptance.
- in_value=32'hFFFFFFFF -> out_bcd=40'h4294967295, out_ndig=10; no nibble >9 during SHIFT, checked every cycle.
- in_value=832040 (F30), out_ready held 0 for 50 cycles -> out_valid and out_bcd=40'h0000832040 stable and in_ready=0 throughout; after the handshake in_ready=1 next cycle.
- Accept 12345, assert reset at SHIFT cycle 10 -> out_valid stays 0, in_ready=1 after reset. A fresh 144 then yields 40'h0000000144, ndig 3.
- Drive in_valid with changing in_value during SHIFT -> ignored; the result matches the term accepted at the handshake.
